rr_arb_mux: RTL
===============

Name: rr_arb_mux

Overview:
- Registered N-input arbitrating multiplexer: successor to the combinational address-select mux.
- N = 2**ADDRESS_WIDTH producer channels present data on one flattened bus, each with a valid/ready handshake.
- An internal arbiter selects one requesting channel per cycle and captures its word into a single output register, which drains through a downstream valid/ready handshake.
- Used wherever several producers share one sink.

Parameters:
- DATA_WIDTH, 8, width of each channel word.
- ADDRESS_WIDTH, 2, log2 of channel count; N = 2**ADDRESS_WIDTH.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  N*DATA_WIDTH  channel i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- valid_in  input  N  bit i: channel i offers a word.
- ready_out  output  N  bit i: channel i word accepted this cycle when valid_in[i] also high.
- data_out  output  DATA_WIDTH  registered output word.
- valid_out  output  1  data_out holds a word.
- ready_in  input  1  sink accepts data_out this cycle.
- grant_addr  output  ADDRESS_WIDTH  index of the channel whose word is in data_out.

Behaviour:
- Reset is asynchronous on rst_n low and forces:
  - data_out = 0, valid_out = 0, grant_addr = 0.
  - Round-robin pointer = 0.
  - ready_out = 0 while rst_n is low.
- Reset mid-transfer discards the held word; nothing is replayed.
- load = (~valid_out | ready_in) & (|valid_in).
  - This gives a one-entry pipeline with full throughput: a new word is loaded in the same cycle the old one drains.
- Arbitration is combinational, over valid_in only, and produces one-hot grant g.
  - RR_MODE=0: g selects the lowest set index of valid_in.
  - RR_MODE=1: g selects the first set index at or after ptr, searching upward modulo N (wrap from N-1 to 0).
- ready_out = g & {N{~valid_out | ready_in}}.
  - At most one bit is high.
  - ready_out is never asserted for a channel with valid_in low.
- On a load edge:
  - data_out <= selected word.
  - grant_addr <= granted index.
  - valid_out <= 1.
  - RR_MODE=1 only: ptr <= granted index + 1 mod N.
- On a drain without load (valid_out & ready_in & ~|valid_in):
  - valid_out <= 0.
  - data_out and grant_addr hold their last values.
- Stall (valid_out & ~ready_in):
  - data_out, grant_addr, valid_out and ptr all hold.
  - ready_out = 0.
- ptr changes only on an accepted transfer; idle cycles do not advance it.
- Latency: a word accepted on edge k is visible on data_out after edge k.
- Sustained throughput: one word per cycle while ready_in stays high.
- Fairness: in RR_MODE=1, a continuously requesting channel is granted within N accepted transfers.
- Producers must hold valid_in[i] and their data until ready_out[i]. The block does not check this rule; a violation may drop or duplicate words.
- No combinational path from ready_in to valid_out. The path ready_in -> ready_out is combinational by design.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-run with valid_out=1.
  - Required: valid_out, data_out and grant_addr go to 0 immediately without a clock; ready_out=0.
  - After release with valid_in=0: outputs stay 0 and ptr stays 0.
- Single channel (N=4, DW=8):
  - Stimulus: valid_in=4'b0100, word 0xA5, ready_in=1.
  - Required: ready_out=4'b0100; next cycle data_out=0xA5, grant_addr=2, valid_out=1.
  - Then drop valid_in: valid_out=0 one cycle later.
- Round-robin fairness:
  - Stimulus: valid_in=4'b1111 held, per-channel words 0x10..0x13, ready_in=1.
  - Required: grant_addr sequence 0,1,2,3,0,1 with one word per cycle.
  - Repeat with RR_MODE=0: grant_addr stays 0 throughout.
- Wrap-around:
  - Stimulus: after a grant to channel 3 (ptr=0), set valid_in=4'b1010.
  - Required: channel 1 is granted, not 3.
  - Next: with ptr=2 and valid_in=4'b0011, channel 0 is granted.
- Backpressure:
  - Stimulus: valid_out=1, ready_in=0 for 3 cycles, valid_in=4'b0011.
  - Required: ready_out=0, and data_out, grant_addr and ptr are unchanged throughout.
  - On ready_in=1: the old word drains and a new grant loads on the same edge.
- Parameter sweep:
  - Stimulus: ADDRESS_WIDTH=3, DATA_WIDTH=16, random valid_in and ready_in for 10k cycles, checked against a scoreboard.
  - Required: no lost or duplicated words; per-channel order preserved; every grant_addr matches its source channel.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: arbitrates N=2**ADDRESS_WIDTH valid/ready channels (data_in, valid_in, ready_out) into one registered output (data_out, valid_out, grant_addr) drained by ready_in; clk, async active-low rst_n
module rr_arb_mux #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 2,
  parameter int RR_MODE       = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [(2**ADDRESS_WIDTH)*DATA_WIDTH-1:0] data_in,
  input  logic [(2**ADDRESS_WIDTH)-1:0]         valid_in,
  output logic [(2**ADDRESS_WIDTH)-1:0]         ready_out,
  output logic [DATA_WIDTH-1:0]                 data_out,
  output logic                                  valid_out,
  input  logic                                  ready_in,
  output logic [ADDRESS_WIDTH-1:0]              grant_addr
);
  localparam int N = 2**ADDRESS_WIDTH;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDRESS_WIDTH-1:0] grant_q, grant_d, ptr_q, ptr_d, sel, idx;
  logic valid_q, valid_d, any, open, load;
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = (RR_MODE != 0) ? ptr_q + ADDRESS_WIDTH'(k) : ADDRESS_WIDTH'(k);
      sel = valid_in[idx] ? idx : sel;
    end
    any = |valid_in;
    open = (~valid_q | ready_in) & rst_n;
    load = open & any;
    ready_out = load ? N'(1) << sel : '0;
    data_d = load ? data_in[sel*DATA_WIDTH +: DATA_WIDTH] : data_q;
    grant_d = load ? sel : grant_q;
    valid_d = load | (valid_q & ~ready_in);
    ptr_d = (load && RR_MODE != 0) ? sel + 1'b1 : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  assign data_out   = data_q;
  assign grant_addr = grant_q;
  assign valid_out  = valid_q;
endmodule
